// File: rtl/branch_pkg.sv
// Shared branch-resolution types: opcodes, BTB geometry, the per-instruction
// prediction record and the recovery FSM state.
package branch_pkg;

    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam int         BTB_IDX_W = 4;
    localparam int         BR_PC_W   = 32;

    typedef struct packed {
        logic               v;
        logic               hit;
        logic [BR_PC_W-1:0] target;
        logic [BR_PC_W-1:0] pc;
    } pred_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } rec_state_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-side bundle of the branch resolve unit: fetch prediction, execute
// outcome, and the redirect / flush / BTB-write results.
interface branch_resolve_unit_if
    import branch_pkg::*;
#(
    parameter int PC_W  = BR_PC_W,
    parameter int IDX_W = BTB_IDX_W
);
    logic             stall;
    logic             f_valid;
    logic [PC_W-1:0]  f_pc;
    logic             f_hit;
    logic [PC_W-1:0]  f_pred_target;
    logic             e_valid;
    logic             e_is_branch;
    logic             e_taken;
    logic [PC_W-1:0]  e_target;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_fd;
    logic             btb_upd_valid;
    logic [IDX_W-1:0] btb_upd_idx;
    logic             btb_upd_set;
    logic [PC_W-1:0]  btb_upd_target;
    rec_state_t       rec_state;

    // There is no ready path: the unit always accepts. redirect_valid and
    // btb_upd_valid are single-cycle strobes; their payloads are meaningful
    // only in that cycle and read as zero otherwise.
    modport master (
        output stall, f_valid, f_pc, f_hit, f_pred_target,
        output e_valid, e_is_branch, e_taken, e_target,
        input  redirect_valid, redirect_pc, flush_fd,
        input  btb_upd_valid, btb_upd_idx, btb_upd_set, btb_upd_target,
        input  rec_state
    );

    modport slave (
        input  stall, f_valid, f_pc, f_hit, f_pred_target,
        input  e_valid, e_is_branch, e_taken, e_target,
        output redirect_valid, redirect_pc, flush_fd,
        output btb_upd_valid, btb_upd_idx, btb_upd_set, btb_upd_target,
        output rec_state
    );
endinterface

// File: rtl/branch_resolve_unit_pred_track_pipe.sv
// Two-stage (D, E) stall/flush-aware shift register for per-instruction
// metadata; the carried type only needs a 'v' valid field.
module pred_track_pipe
    import branch_pkg::*;
#(
    parameter type T = pred_t
)(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic flush,
    input  T     f_in,
    output T     e_q
);
    T d_q;

    // Flush wins over stall so no wrong-path record survives a recovery.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= '0;
            e_q <= '0;
        end else if (flush) begin
            d_q.v <= 1'b0;
            e_q.v <= 1'b0;
        end else if (!stall) begin
            d_q <= f_in;
            e_q <= d_q;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side BTB prediction checker: redirects fetch, flushes F/D and trains
// the BTB on a mispredict. Optional counters under BRANCH_PERF_CNT_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = BR_PC_W,
    parameter int IDX_W     = BTB_IDX_W,
    parameter int FLUSH_CYC = 2
`ifdef BRANCH_PERF_CNT_EN
    , parameter int CNT_W   = 16
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
`ifdef BRANCH_PERF_CNT_EN
    , output logic [CNT_W-1:0]    branch_cnt
    , output logic [CNT_W-1:0]    mispred_cnt
`endif
);
    localparam int CW = $clog2(FLUSH_CYC + 1);

    rec_state_t      state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    pred_t           f_pred, e_q;
    logic            flush, cmp_en, taken, mispred, upd_set;
    logic [PC_W-1:0] pc4, new_pc, new_tgt;

    assign f_pred = '{v: bus.f_valid, hit: bus.f_hit,
                      target: bus.f_pred_target, pc: bus.f_pc};

    pred_track_pipe #(.T(pred_t)) u_track (
        .clk   (clk),
        .reset (reset),
        .stall (bus.stall),
        .flush (flush),
        .f_in  (f_pred),
        .e_q   (e_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (mispred) begin
                state_next = RECOVER;
                cnt_next   = CW'(FLUSH_CYC);
            end
            RECOVER: if (!bus.stall) begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results of the E-stage compare; registered below for one-cycle latency.
    always_comb begin
        flush   = (state == RECOVER);
        cmp_en  = (state == IDLE) && bus.e_valid && e_q.v;
        taken   = bus.e_is_branch && bus.e_taken;
        pc4     = e_q.pc + PC_W'(4);
        new_pc  = pc4;
        new_tgt = '0;
        upd_set = 1'b0;
        mispred = 1'b0;
        if (taken) begin
            new_pc  = bus.e_target;
            new_tgt = bus.e_target;
            upd_set = 1'b1;
            mispred = cmp_en && (!e_q.hit || (e_q.target != bus.e_target));
        end else begin
            mispred = cmp_en && e_q.hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.btb_upd_valid  <= 1'b0;
            bus.btb_upd_idx    <= '0;
            bus.btb_upd_set    <= 1'b0;
            bus.btb_upd_target <= '0;
        end else begin
            bus.redirect_valid <= mispred;
            bus.redirect_pc    <= mispred ? new_pc : '0;
            bus.btb_upd_valid  <= mispred;
            bus.btb_upd_idx    <= mispred ? e_q.pc[IDX_W+1:2] : '0;
            bus.btb_upd_set    <= mispred && upd_set;
            bus.btb_upd_target <= mispred ? new_tgt : '0;
        end
    end

    assign bus.flush_fd  = flush;
    assign bus.rec_state = state;

`ifdef BRANCH_PERF_CNT_EN
    // Saturating: once all-ones a counter stays there until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (cmp_en && bus.e_is_branch && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispred && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a behavioural model. Covers BRANCH_PERF_CNT_EN when defined.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    branch_resolve_unit_if #(.PC_W(32), .IDX_W(4)) bus ();

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
`endif

    branch_resolve_unit #(
        .PC_W(32), .IDX_W(4), .FLUSH_CYC(FLUSH_CYC)
`ifdef BRANCH_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRANCH_PERF_CNT_EN
        , .branch_cnt  (branch_cnt)
        , .mispred_cnt (mispred_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish (got running, required finished)");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.stall = 0; bus.f_valid = 0; bus.f_pc = '0; bus.f_hit = 0; bus.f_pred_target = '0;
        bus.e_valid = 0; bus.e_is_branch = 0; bus.e_taken = 0; bus.e_target = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Pushes one fetch record and returns with it sitting in the E stage.
    task automatic fetch_into_e(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        bus.f_valid = 1; bus.f_pc = pc; bus.f_hit = hit; bus.f_pred_target = tgt;
        tick();
        bus.f_valid = 0; bus.f_hit = 0;
        tick();
    endtask

    task automatic drive_e(input logic br, input logic tk, input logic [31:0] tgt);
        bus.e_valid = 1; bus.e_is_branch = br; bus.e_taken = tk; bus.e_target = tgt;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset redirect_valid: got %b required 0", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset redirect_pc: got %h required 0", bus.redirect_pc); end
        n_checks++; if (bus.flush_fd !== 1'b0) begin n_fail++; $display("FAIL reset flush_fd: got %b required 0", bus.flush_fd); end
        n_checks++; if (bus.btb_upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset btb_upd_valid: got %b required 0", bus.btb_upd_valid); end
        n_checks++; if (bus.rec_state !== IDLE) begin n_fail++; $display("FAIL reset rec_state: got %0d required IDLE", bus.rec_state); end
    endtask

    task automatic test_miss_taken();
        do_reset();
        fetch_into_e(32'h40, 1'b0, 32'h0);
        drive_e(1, 1, 32'h80);
        tick();
        drive_idle();
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL miss_taken redirect_valid: got %b required 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h80) begin n_fail++; $display("FAIL miss_taken redirect_pc: got %h required 80", bus.redirect_pc); end
        n_checks++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_set !== 1'b1) begin n_fail++; $display("FAIL miss_taken btb_upd v/set: got %b%b required 11", bus.btb_upd_valid, bus.btb_upd_set); end
        n_checks++; if (bus.btb_upd_idx !== 4'd0) begin n_fail++; $display("FAIL miss_taken btb_upd_idx: got %0d required 0", bus.btb_upd_idx); end
        n_checks++; if (bus.btb_upd_target !== 32'h80) begin n_fail++; $display("FAIL miss_taken btb_upd_target: got %h required 80", bus.btb_upd_target); end
        n_checks++; if (bus.flush_fd !== 1'b1) begin n_fail++; $display("FAIL miss_taken flush_fd c1: got %b required 1", bus.flush_fd); end
        tick();
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.btb_upd_valid !== 1'b0) begin n_fail++; $display("FAIL miss_taken pulse width: got %b%b required 00", bus.redirect_valid, bus.btb_upd_valid); end
        n_checks++; if (bus.flush_fd !== 1'b1) begin n_fail++; $display("FAIL miss_taken flush_fd c2: got %b required 1", bus.flush_fd); end
        tick();
        n_checks++; if (bus.flush_fd !== 1'b0) begin n_fail++; $display("FAIL miss_taken flush_fd c3: got %b required 0", bus.flush_fd); end
        n_checks++; if (bus.rec_state !== IDLE) begin n_fail++; $display("FAIL miss_taken rec_state: got %0d required IDLE", bus.rec_state); end
    endtask

    task automatic test_hit_correct();
        int flushes = 0;
        int pulses  = 0;
        do_reset();
        fetch_into_e(32'h40, 1'b1, 32'h80);
        drive_e(1, 1, 32'h80);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_idle();
            if (bus.flush_fd) flushes++;
            if (bus.redirect_valid || bus.btb_upd_valid) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL hit_correct outputs: got %0d pulses required 0", pulses); end
        n_checks++; if (flushes != 0) begin n_fail++; $display("FAIL hit_correct flush_fd: got %0d cycles required 0", flushes); end
    endtask

    task automatic test_hit_not_taken();
        do_reset();
        fetch_into_e(32'h44, 1'b1, 32'h80);
        drive_e(1, 0, 32'h80);
        tick();
        drive_idle();
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h48) begin n_fail++; $display("FAIL not_taken redirect: got %b/%h required 1/48", bus.redirect_valid, bus.redirect_pc); end
        n_checks++; if (bus.btb_upd_valid !== 1'b1 || bus.btb_upd_set !== 1'b0) begin n_fail++; $display("FAIL not_taken btb v/set: got %b%b required 10", bus.btb_upd_valid, bus.btb_upd_set); end
        n_checks++; if (bus.btb_upd_idx !== 4'd1) begin n_fail++; $display("FAIL not_taken btb_upd_idx: got %0d required 1", bus.btb_upd_idx); end
    endtask

    task automatic test_wrong_target();
        do_reset();
        // Keep fetching so a wrong-path record is valid in E during recovery.
        bus.f_valid = 1; bus.f_pc = 32'h40; bus.f_hit = 1; bus.f_pred_target = 32'h80;
        tick();
        bus.f_pc = 32'h44; bus.f_hit = 1; bus.f_pred_target = 32'h100;
        tick();
        drive_e(1, 1, 32'h90);
        tick();
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h90) begin n_fail++; $display("FAIL wrong_target redirect: got %b/%h required 1/90", bus.redirect_valid, bus.redirect_pc); end
        n_checks++; if (bus.btb_upd_set !== 1'b1 || bus.btb_upd_target !== 32'h90) begin n_fail++; $display("FAIL wrong_target btb: got %b/%h required 1/90", bus.btb_upd_set, bus.btb_upd_target); end
        drive_e(1, 1, 32'h200);
        tick();
        drive_idle();
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.btb_upd_valid !== 1'b0) begin n_fail++; $display("FAIL wrong_target recover_ignore: got %b%b required 00", bus.redirect_valid, bus.btb_upd_valid); end
    endtask

    task automatic test_stall_recover();
        int flushes = 0;
        int pulses  = 1;
        do_reset();
        fetch_into_e(32'h40, 1'b0, 32'h0);
        drive_e(1, 1, 32'h80);
        tick();
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_recover first pulse: got %b required 1", bus.redirect_valid); end
        for (int i = 0; i < 10; i++) begin
            if (bus.flush_fd) flushes++;
            bus.stall = (i < 3);
            tick();
            if (bus.redirect_valid) pulses++;
        end
        drive_idle();
        n_checks++; if (flushes != FLUSH_CYC + 3) begin n_fail++; $display("FAIL stall_recover flush length: got %0d required %0d", flushes, FLUSH_CYC + 3); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL stall_recover redirect pulses: got %0d required 1", pulses); end
    endtask

    task automatic test_stall_detect();
        int pulses = 0;
        do_reset();
        fetch_into_e(32'h50, 1'b1, 32'h80);
        drive_e(1, 0, 32'h0);
        bus.stall = 1;
        tick();
        bus.stall = 0;
        bus.e_valid = 0;
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h54) begin n_fail++; $display("FAIL stall_detect redirect: got %b/%h required 1/54", bus.redirect_valid, bus.redirect_pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.redirect_valid) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL stall_detect re-pulse: got %0d required 0", pulses); end
    endtask

    task automatic test_reset_mid_recover();
        do_reset();
        fetch_into_e(32'h40, 1'b0, 32'h0);
        drive_e(1, 1, 32'h80);
        tick();
        drive_idle();
        tick();
        reset = 1;
        tick();
        n_checks++; if (bus.flush_fd !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.btb_upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid outputs: got f%b r%b u%b required 000", bus.flush_fd, bus.redirect_valid, bus.btb_upd_valid); end
        n_checks++; if (bus.rec_state !== IDLE) begin n_fail++; $display("FAIL reset_mid rec_state: got %0d required IDLE", bus.rec_state); end
        reset = 0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        fetch_into_e(32'hFFFF_FFFC, 1'b1, 32'h80);
        drive_e(0, 0, 32'h0);
        tick();
        drive_idle();
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap redirect: got %b/%h required 1/0", bus.redirect_valid, bus.redirect_pc); end
        n_checks++; if (bus.btb_upd_idx !== 4'hF) begin n_fail++; $display("FAIL pc_wrap btb_upd_idx: got %0d required 15", bus.btb_upd_idx); end
    endtask

`ifdef BRANCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive_idle();
            bus.f_valid = 1; bus.f_pc = 32'h100 + 32'(c * 4);
            if (c >= 2 && c <= 4) drive_e(1, 0, 32'h0);
            if (c == 5 || c == 10) drive_e(1, 1, 32'h300);
            tick();
        end
        drive_idle();
        n_checks++; if (branch_cnt !== CNT_W'(5)) begin n_fail++; $display("FAIL perf branch_cnt: got %0d required 5", branch_cnt); end
        n_checks++; if (mispred_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL perf mispred_cnt: got %0d required 2", mispred_cnt); end
    endtask
`endif

    // ---------------- randomized run vs behavioural model ----------------
    typedef struct {
        bit          v;
        bit          hit;
        logic [31:0] tgt;
        logic [31:0] pc;
    } rec_t;

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return 32'h80;
            1:       return 32'h90;
            default: return $urandom() & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic test_random();
        rec_t        md, me, fin;
        int          flush_left;
        int          bc, mc;
        bit          stall, cmp, mis, tk;
        logic [31:0] epc, etgt;
        logic [3:0]  eidx;
        bit          eset;
        int          errs_before;
        do_reset();
        md = '{0, 0, 0, 0}; me = '{0, 0, 0, 0};
        flush_left = 0; bc = 0; mc = 0;
        errs_before = n_fail;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            stall   = ($urandom_range(0, 4) == 0);
            fin.v   = ($urandom_range(0, 3) != 0);
            fin.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255) * 4);
            fin.hit = $urandom_range(0, 1);
            fin.tgt = pick_target();
            bus.stall = stall; bus.f_valid = fin.v; bus.f_pc = fin.pc;
            bus.f_hit = fin.hit; bus.f_pred_target = fin.tgt;
            bus.e_valid = ($urandom_range(0, 4) != 0);
            bus.e_is_branch = ($urandom_range(0, 9) < 7);
            bus.e_taken = $urandom_range(0, 1);
            bus.e_target = ($urandom_range(0, 1) == 0) ? me.tgt : pick_target();

            // Expected outcome from the outcome table.
            cmp  = (flush_left == 0) && bus.e_valid && me.v;
            tk   = bus.e_is_branch && bus.e_taken;
            eidx = 4'((me.pc / 4) % 16);
            if (tk) begin
                mis = !me.hit || (me.tgt != bus.e_target);
                epc = bus.e_target; etgt = bus.e_target; eset = 1;
            end else begin
                mis = me.hit;
                epc = me.pc + 32'd4; etgt = 32'h0; eset = 0;
            end
            mis = cmp && mis;
            if (cmp && bus.e_is_branch && bc < (1 << CNT_W) - 1) bc++;
            if (mis && mc < (1 << CNT_W) - 1) mc++;

            tick();

            if (flush_left > 0) begin
                md.v = 0; me.v = 0;
            end else if (!stall) begin
                me = md; md = fin;
            end
            if (mis) flush_left = FLUSH_CYC;
            else if (flush_left > 0 && !stall) flush_left--;

            n_checks++; if (bus.redirect_valid !== mis) begin n_fail++; $display("FAIL rnd%0d redirect_valid: got %b required %b", cyc, bus.redirect_valid, mis); end
            n_checks++; if (bus.btb_upd_valid !== mis) begin n_fail++; $display("FAIL rnd%0d btb_upd_valid: got %b required %b", cyc, bus.btb_upd_valid, mis); end
            n_checks++; if (bus.redirect_pc !== (mis ? epc : 32'h0)) begin n_fail++; $display("FAIL rnd%0d redirect_pc: got %h required %h", cyc, bus.redirect_pc, mis ? epc : 32'h0); end
            n_checks++; if (bus.btb_upd_idx !== (mis ? eidx : 4'h0)) begin n_fail++; $display("FAIL rnd%0d btb_upd_idx: got %0d required %0d", cyc, bus.btb_upd_idx, mis ? eidx : 4'h0); end
            n_checks++; if (bus.btb_upd_set !== (mis && eset)) begin n_fail++; $display("FAIL rnd%0d btb_upd_set: got %b required %b", cyc, bus.btb_upd_set, mis && eset); end
            n_checks++; if (bus.btb_upd_target !== (mis ? etgt : 32'h0)) begin n_fail++; $display("FAIL rnd%0d btb_upd_target: got %h required %h", cyc, bus.btb_upd_target, mis ? etgt : 32'h0); end
            n_checks++; if (bus.flush_fd !== (flush_left > 0)) begin n_fail++; $display("FAIL rnd%0d flush_fd: got %b required %b", cyc, bus.flush_fd, flush_left > 0); end
`ifdef BRANCH_PERF_CNT_EN
            n_checks++; if (branch_cnt !== CNT_W'(bc)) begin n_fail++; $display("FAIL rnd%0d branch_cnt: got %0d required %0d", cyc, branch_cnt, bc); end
            n_checks++; if (mispred_cnt !== CNT_W'(mc)) begin n_fail++; $display("FAIL rnd%0d mispred_cnt: got %0d required %0d", cyc, mispred_cnt, mc); end
`endif
            if (n_fail - errs_before > 20) break;
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1;
        drive_idle();
        test_reset();
        test_miss_taken();
        test_hit_correct();
        test_hit_not_taken();
        test_wrong_target();
        test_stall_recover();
        test_stall_detect();
        test_reset_mid_recover();
        test_pc_wrap();
`ifdef BRANCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
